// File: rtl/switch_pkg.sv
// Shared egress-switch definitions: port count, cell geometry, dispatcher
// state encoding and the read-return tag that travels beside each buffer read.
package switch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_W     = 2;
  localparam int CELL_BEATS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_READ = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    logic              first_beat;
  } rd_tag_t;

endpackage

// File: rtl/cell_out_dispatch_if.sv
// Cell descriptor channel from the output scheduler to the dispatcher.
// Handshake: a descriptor transfers on a rising clk edge where cell_valid and
// cell_ready are both high; the master holds all fields stable while valid is
// high and not yet accepted, and ready never depends on valid.
interface cell_out_dispatch_if #(
  parameter int ADDR_W = 10
) ();

  logic              cell_valid;
  logic              cell_ready;
  logic [1:0]        cell_port;
  logic [ADDR_W-1:0] cell_addr;
  logic              cell_first;
  logic              cell_last;
  logic [2:0]        cell_pad;

  modport master (
    output cell_valid, cell_port, cell_addr, cell_first, cell_last, cell_pad,
    input  cell_ready
  );

  modport slave (
    input  cell_valid, cell_port, cell_addr, cell_first, cell_last, cell_pad,
    output cell_ready
  );

endinterface

// File: rtl/cell_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligning each tag with the data
// the cell buffer returns for that read. clr wipes every in-flight tag.
module cell_rd_tag_pipe
  import switch_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [RD_LAT];
  rd_tag_t stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/cell_out_dispatch.sv
// Egress cell dispatcher: takes a descriptor, waits for the target port's
// backpressure to clear, then streams the whole cell from the buffer to it.
module cell_out_dispatch
  import switch_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int CELL_BEATS = switch_pkg::CELL_BEATS,
  parameter int RD_LAT     = 2,
  localparam int BEAT_W    = $clog2(CELL_BEATS)
) (
  input  logic                     clk,
  input  logic                     reset,
  cell_out_dispatch_if.slave       desc,
  output logic                     mem_rd_en,
  output logic [ADDR_W+BEAT_W-1:0] mem_rd_addr,
  input  logic [63:0]              mem_rd_data,
  output logic [63:0]              pktout_data_0,
  output logic [63:0]              pktout_data_1,
  output logic [63:0]              pktout_data_2,
  output logic [63:0]              pktout_data_3,
  output logic                     pktout_data_wr_0,
  output logic                     pktout_data_wr_1,
  output logic                     pktout_data_wr_2,
  output logic                     pktout_data_wr_3,
  output logic                     o_cell_first,
  output logic                     o_cell_last,
  output logic [2:0]               o_pad_num_64,
  output logic [NUM_PORTS-1:0]     o_vaild,
  input  logic [NUM_PORTS-1:0]     o_cell_bp,
  output dispatch_state_e          dbg_state
);

  dispatch_state_e     state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [2:0]          pad_q, pad_d;

  logic [63:0]          data_q, data_d;
  logic [NUM_PORTS-1:0] wr_q, wr_d;
  logic [NUM_PORTS-1:0] vaild_q, vaild_d;
  logic                 sb_first_q, sb_first_d;
  logic                 sb_last_q, sb_last_d;
  logic [2:0]           sb_pad_q, sb_pad_d;

  rd_tag_t tag_in;
  rd_tag_t ret_tag;

  assign desc.cell_ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    port_d     = port_q;
    addr_d     = addr_q;
    first_d    = first_q;
    last_d     = last_q;
    pad_d      = pad_q;
    case (state_q)
      ST_IDLE: begin
        if (desc.cell_valid && desc.cell_ready) begin
          port_d  = desc.cell_port;
          addr_d  = desc.cell_addr;
          first_d = desc.cell_first;
          last_d  = desc.cell_last;
          pad_d   = desc.cell_pad;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!o_cell_bp[port_q]) begin
          beat_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        // Backpressure is deliberately not looked at here: cells are atomic.
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        if (beat_cnt_q == BEAT_W'(CELL_BEATS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_rd_en   = (state_q == ST_READ);
  assign mem_rd_addr = {addr_q, beat_cnt_q};
  assign tag_in      = '{valid:      (state_q == ST_READ),
                         port:       port_q,
                         first_beat: (beat_cnt_q == '0)};

  cell_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (reset),
    .tag_in  (tag_in),
    .tag_out (ret_tag)
  );

  // Latched sideband stays intact until the next handshake, which comes at
  // least CELL_BEATS cycles after the first read, so RD_LAT <= CELL_BEATS.
  always_comb begin
    data_d     = data_q;
    wr_d       = '0;
    vaild_d    = '0;
    sb_first_d = sb_first_q;
    sb_last_d  = sb_last_q;
    sb_pad_d   = sb_pad_q;
    if (ret_tag.valid) begin
      data_d = mem_rd_data;
      wr_d   = NUM_PORTS'(1) << ret_tag.port;
      if (ret_tag.first_beat) begin
        vaild_d    = NUM_PORTS'(1) << ret_tag.port;
        sb_first_d = first_q;
        sb_last_d  = last_q;
        sb_pad_d   = pad_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      port_q     <= '0;
      addr_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      pad_q      <= '0;
      data_q     <= '0;
      wr_q       <= '0;
      vaild_q    <= '0;
      sb_first_q <= 1'b0;
      sb_last_q  <= 1'b0;
      sb_pad_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      pad_q      <= pad_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      vaild_q    <= vaild_d;
      sb_first_q <= sb_first_d;
      sb_last_q  <= sb_last_d;
      sb_pad_q   <= sb_pad_d;
    end
  end

  assign pktout_data_0    = data_q;
  assign pktout_data_1    = data_q;
  assign pktout_data_2    = data_q;
  assign pktout_data_3    = data_q;
  assign pktout_data_wr_0 = wr_q[0];
  assign pktout_data_wr_1 = wr_q[1];
  assign pktout_data_wr_2 = wr_q[2];
  assign pktout_data_wr_3 = wr_q[3];
  assign o_vaild          = vaild_q;
  assign o_cell_first     = sb_first_q;
  assign o_cell_last      = sb_last_q;
  assign o_pad_num_64     = sb_pad_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cell_out_dispatch.sv
// Directed bench for cell_out_dispatch: cycle-exact checks per cell plus a
// write scoreboard fed from a model of the cell buffer.
module tb_cell_out_dispatch;
  import switch_pkg::*;

  localparam int TB_ADDR_W = 10;
  localparam int TB_RD_LAT = 2;
  localparam int TB_BEAT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- DUT ----------------
  cell_out_dispatch_if #(.ADDR_W(TB_ADDR_W)) desc_if ();

  logic                            mem_rd_en;
  logic [TB_ADDR_W+TB_BEAT_W-1:0]  mem_rd_addr;
  logic [63:0]                     mem_rd_data;
  logic [63:0]                     pktout_data_0, pktout_data_1, pktout_data_2, pktout_data_3;
  logic                            pktout_data_wr_0, pktout_data_wr_1, pktout_data_wr_2, pktout_data_wr_3;
  logic                            o_cell_first, o_cell_last;
  logic [2:0]                      o_pad_num_64;
  logic [3:0]                      o_vaild;
  logic [3:0]                      o_cell_bp;
  dispatch_state_e                 dbg_state;
  logic [3:0]                      wr_vec;

  assign wr_vec = {pktout_data_wr_3, pktout_data_wr_2, pktout_data_wr_1, pktout_data_wr_0};

  cell_out_dispatch #(
    .ADDR_W     (TB_ADDR_W),
    .CELL_BEATS (CELL_BEATS),
    .RD_LAT     (TB_RD_LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .desc             (desc_if),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .pktout_data_0    (pktout_data_0),
    .pktout_data_1    (pktout_data_1),
    .pktout_data_2    (pktout_data_2),
    .pktout_data_3    (pktout_data_3),
    .pktout_data_wr_0 (pktout_data_wr_0),
    .pktout_data_wr_1 (pktout_data_wr_1),
    .pktout_data_wr_2 (pktout_data_wr_2),
    .pktout_data_wr_3 (pktout_data_wr_3),
    .o_cell_first     (o_cell_first),
    .o_cell_last      (o_cell_last),
    .o_pad_num_64     (o_pad_num_64),
    .o_vaild          (o_vaild),
    .o_cell_bp        (o_cell_bp),
    .dbg_state        (dbg_state)
  );

  // ---------------- cell buffer model ----------------
  function automatic logic [63:0] mem_word(input logic [TB_ADDR_W+TB_BEAT_W-1:0] a);
    return {32'hCAFE_0000 | {19'b0, a}, 32'h5A5A_5A5A ^ {19'b0, a}};
  endfunction

  logic [63:0] rd_pipe [TB_RD_LAT];
  always_ff @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? mem_word(mem_rd_addr) : 64'h0;
    for (int i = 1; i < TB_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[TB_RD_LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int p);
    return 4'(1 << p);
  endfunction

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q [$];
  int          wr_log [$];
  logic [3:0]  vaild_log [$];
  logic [65:0] sb_e;

  always @(negedge clk) begin
    if (wr_vec != 4'b0) begin
      wr_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("wr_unexp", 64'(wr_vec), 64'h0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("wr_port", 64'(wr_vec), 64'(oh(int'(sb_e[65:64]))));
        chk("wr_data0", pktout_data_0, sb_e[63:0]);
        chk("wr_data3", pktout_data_3, sb_e[63:0]);
      end
    end
    if (o_vaild != 4'b0) vaild_log.push_back(o_vaild);
  end

  task automatic push_cell(input int port, input int addr);
    for (int j = 0; j < CELL_BEATS; j++)
      exp_q.push_back({2'(port), mem_word({10'(addr), 3'(j)})});
  endtask

  // ---------------- driver tasks ----------------
  // One cell; s = cycle (after handshake) of the first read. s > 2 means the
  // own-port bp is held until s-1 and re-asserted mid-READ.
  task automatic run_cell(input int port, input int addr, input logic first,
                          input logic last, input logic [2:0] pad,
                          input logic [3:0] bp_base, input int s);
    logic [3:0] own;
    own = oh(port);
    @(negedge clk);
    desc_if.cell_valid = 1'b1;
    desc_if.cell_port  = 2'(port);
    desc_if.cell_addr  = 10'(addr);
    desc_if.cell_first = first;
    desc_if.cell_last  = last;
    desc_if.cell_pad   = pad;
    o_cell_bp = bp_base | ((s > 2) ? own : 4'b0);
    chk("ready_idle", 64'(desc_if.cell_ready), 64'h1);
    @(posedge clk);
    push_cell(port, addr);
    #1 desc_if.cell_valid = 1'b0;
    for (int k = 1; k <= s + TB_RD_LAT + 9; k++) begin
      @(negedge clk);
      chk("state", 64'(dbg_state),
          64'((k < s) ? ST_ARB : (k < s + CELL_BEATS) ? ST_READ : ST_IDLE));
      chk("rd_en", 64'(mem_rd_en), 64'((k >= s && k < s + CELL_BEATS) ? 1 : 0));
      if (k >= s && k < s + CELL_BEATS)
        chk("rd_addr", 64'(mem_rd_addr), 64'({10'(addr), 3'(k - s)}));
      chk("wr_vec", 64'(wr_vec),
          64'((k > s + TB_RD_LAT && k <= s + TB_RD_LAT + CELL_BEATS) ? own : 4'b0));
      chk("vaild", 64'(o_vaild), 64'((k == s + TB_RD_LAT + 1) ? own : 4'b0));
      if (k == s + TB_RD_LAT + 1) begin
        chk("sb_first", 64'(o_cell_first), 64'(first));
        chk("sb_last", 64'(o_cell_last), 64'(last));
        chk("sb_pad", 64'(o_pad_num_64), 64'(pad));
      end
      o_cell_bp = bp_base | ((k < s - 1) ? own : 4'b0)
                | ((s > 2 && k >= s + 3 && k < s + CELL_BEATS) ? own : 4'b0);
    end
    o_cell_bp = 4'b0;
  endtask

  // ---------------- stimulus ----------------
  int hs_cyc [4];
  int wait_n;
  int ok;

  initial begin
    reset = 1'b1;
    o_cell_bp = 4'b0;
    desc_if.cell_valid = 1'b0;
    desc_if.cell_port  = '0;
    desc_if.cell_addr  = '0;
    desc_if.cell_first = 1'b0;
    desc_if.cell_last  = 1'b0;
    desc_if.cell_pad   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(desc_if.cell_ready), 64'h0);
    chk("rst_wr", 64'(wr_vec), 64'h0);
    chk("rst_vaild", 64'(o_vaild), 64'h0);
    chk("rst_data", pktout_data_0, 64'h0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(desc_if.cell_ready), 64'h1);

    // Single cell, port 2, addr 0x05
    run_cell(2, 10'h005, 1'b1, 1'b1, 3'd3, 4'b0000, 2);
    // Own-port bp held 20 cycles, re-asserted mid-READ
    run_cell(1, 10'h0A3, 1'b1, 1'b0, 3'd0, 4'b0000, 22);
    // bp on every other port is irrelevant
    run_cell(0, 10'h200, 1'b0, 1'b1, 3'd5, 4'b1110, 2);

    // Back-to-back descriptors, valid held high
    wr_log.delete();
    vaild_log.delete();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      desc_if.cell_valid = 1'b1;
      desc_if.cell_port  = 2'(p);
      desc_if.cell_addr  = 10'(16 + p);
      desc_if.cell_first = (p == 0);
      desc_if.cell_last  = (p == 3);
      desc_if.cell_pad   = 3'(p + 1);
      wait_n = 0;
      while (!desc_if.cell_ready && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      chk("b2b_hs_wait", 64'(desc_if.cell_ready), 64'h1);
      hs_cyc[p] = cyc;
      push_cell(p, 16 + p);
      @(posedge clk);
      #1;
    end
    desc_if.cell_valid = 1'b0;
    repeat (25) @(negedge clk);
    for (int p = 1; p < 4; p++)
      chk("b2b_period", 64'(hs_cyc[p] - hs_cyc[p-1]), 64'd10);
    chk("b2b_wr_count", 64'(wr_log.size()), 64'd32);
    if (wr_log.size() >= 32) begin
      for (int i = 0; i < 4; i++) begin
        chk("b2b_first_wr", 64'(wr_log[8*i]), 64'(hs_cyc[i] + 3 + TB_RD_LAT));
        ok = 1;
        for (int j = 1; j < 8; j++)
          if (wr_log[8*i+j] != wr_log[8*i] + j) ok = 0;
        chk("b2b_contig", 64'(ok), 64'h1);
      end
    end
    chk("b2b_vaild_count", 64'(vaild_log.size()), 64'd4);
    if (vaild_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("b2b_vaild_seq", 64'(vaild_log[i]), 64'(oh(i)));

    // Reset while the fifth beat is being read
    @(negedge clk);
    desc_if.cell_valid = 1'b1;
    desc_if.cell_port  = 2'd3;
    desc_if.cell_addr  = 10'h010;
    desc_if.cell_first = 1'b1;
    desc_if.cell_last  = 1'b0;
    desc_if.cell_pad   = 3'd6;
    chk("rst_ready_idle", 64'(desc_if.cell_ready), 64'h1);
    @(posedge clk);
    push_cell(3, 10'h010);
    #1 desc_if.cell_valid = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    chk("mid_rd_addr", 64'(mem_rd_addr), 64'({10'h010, 3'd4}));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr", 64'(wr_vec), 64'h0);
    chk("mid_rst_vaild", 64'(o_vaild), 64'h0);
    chk("mid_rst_data", pktout_data_0, 64'h0);
    chk("mid_rst_pad", 64'(o_pad_num_64), 64'h0);
    chk("mid_rst_first", 64'(o_cell_first), 64'h0);
    chk("mid_rst_rd_en", 64'(mem_rd_en), 64'h0);
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("mid_rst_ready", 64'(desc_if.cell_ready), 64'h0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_ready", 64'(desc_if.cell_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_wr", 64'(wr_vec), 64'h0);
      @(negedge clk);
    end

    run_cell(1, 10'h3FF, 1'b0, 1'b0, 3'd7, 4'b0000, 2);

    chk("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
